// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned 64-bit multiply/divide sequencer that time-shares the ALU adder.
// Latency: accept edge + 64 iteration edges; done_o high in the cycle after the last iteration.
// Backpressure: single operation in flight; req_i is only sampled while idle, kill_i aborts RUN.
module alu_muldiv_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        div_i,
    input  logic [63:0] opA_i,
    input  logic [63:0] opB_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o,
    output logic [63:0] rem_o,
    output logic [63:0] alu_a_o,
    output logic [63:0] alu_b_o,
    output logic        alu_cflag_o,
    output logic        alu_sum_en_o,
    output logic        alu_invB_en_o,
    output logic        alu_and_en_o,
    output logic        alu_xor_en_o,
    output logic        alu_lsh_en_o,
    output logic        alu_rsh_en_o,
    output logic        alu_ltu_en_o,
    output logic        alu_lts_en_o,
    input  logic [63:0] alu_out_i,
    input  logic        alu_cflag_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic        is_div;

    // Multiply working set: shift-and-add, multiplicand walks left, multiplier walks right.
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [63:0] mplier;

    // Divide working set: restoring division, quotient bits shift in from the right of quo
    // while the dividend bits shift out of its top into the partial remainder.
    logic [63:0] rem;
    logic [63:0] quo;
    logic [63:0] dvs;

    logic        in_run;
    logic        iterate;
    logic [63:0] s_rem;
    logic        take;
    logic [63:0] acc_nxt;
    logic [63:0] rem_nxt;
    logic [63:0] quo_nxt;

    assign in_run  = (state == ST_RUN);
    assign iterate = in_run && !kill_i;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign s_rem = {rem[62:0], quo[63]};

    // rem[63] set means the shifted remainder is really a 65-bit value, which always
    // exceeds any 64-bit divisor even though the 64-bit subtract reports a borrow.
    assign take = rem[63] | alu_cflag_i;

    // Next-iteration values built from the ALU result for the current cycle.
    always_comb begin
        acc_nxt = mplier[0] ? alu_out_i : acc;
        rem_nxt = take ? alu_out_i : s_rem;
        quo_nxt = {quo[62:0], take};
    end

    // ALU operand/enable drive: adder only, and everything quiet outside RUN.
    always_comb begin
        alu_a_o       = 64'd0;
        alu_b_o       = 64'd0;
        alu_cflag_o   = 1'b0;
        alu_sum_en_o  = 1'b0;
        alu_invB_en_o = 1'b0;
        if (in_run) begin
            alu_sum_en_o  = 1'b1;
            alu_a_o       = is_div ? s_rem : acc;
            alu_b_o       = is_div ? dvs : mcand;
            alu_invB_en_o = is_div;
            alu_cflag_o   = is_div;
        end
    end

    assign alu_and_en_o = 1'b0;
    assign alu_xor_en_o = 1'b0;
    assign alu_lsh_en_o = 1'b0;
    assign alu_rsh_en_o = 1'b0;
    assign alu_ltu_en_o = 1'b0;
    assign alu_lts_en_o = 1'b0;

    assign busy_o = (state != ST_IDLE);
    assign done_o = (state == ST_DONE);

    // Control FSM and iteration counter; kill wins over the final iteration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            cnt    <= 6'd0;
            is_div <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        state  <= ST_RUN;
                        cnt    <= 6'd63;
                        is_div <= div_i;
                    end
                end
                ST_RUN: begin
                    if (kill_i) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd0) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Working registers: load on accept, one add/subtract step per RUN cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc    <= 64'd0;
            mcand  <= 64'd0;
            mplier <= 64'd0;
            rem    <= 64'd0;
            quo    <= 64'd0;
            dvs    <= 64'd0;
        end else if ((state == ST_IDLE) && req_i) begin
            acc    <= 64'd0;
            mcand  <= opA_i;
            mplier <= opB_i;
            rem    <= 64'd0;
            quo    <= opA_i;
            dvs    <= opB_i;
        end else if (iterate) begin
            if (is_div) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end else begin
                acc    <= acc_nxt;
                mcand  <= {mcand[62:0], 1'b0};
                mplier <= {1'b0, mplier[63:1]};
            end
        end
    end

    // Result latch: updated only by a completed operation, held through accept and kill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o <= 64'd0;
            rem_o    <= 64'd0;
        end else if (iterate && (cnt == 6'd0)) begin
            result_o <= is_div ? quo_nxt : acc_nxt;
            rem_o    <= is_div ? rem_nxt : 64'd0;
        end
    end

endmodule
